mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of EX.
- Consumes the 139-bit EX_MEM bus and performs the data-memory/peripheral access through a req/ack handshake, stalling the pipe on wait states.
- Selects the writeback value and registers the 38-bit MEM_WB bus.
- Exports the EX_MEM and MEM_WB forwarding taps consumed by EX.
- Supports IRQ backup/recovery of its pipeline register.

Parameters:
- TIMEOUT, 255: max wait cycles for mem_ack before the access is aborted (1..255).
- CNT_W, 8: wait-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- reset_b  in  1  asynchronous active-low reset
- EX_MEM  in  139  [31:0] store data, [63:32] ALU result/address, [68:64] WriteReg, [69] MemRead, [70] MemWrite, [71] RegWrite, [73:72] MemToReg, [105:74] PC_Plus4, [137:106] LUData, [138] LUOp
- IRQ_BACKUP  in  1  save MEM_WB, flush
- IRQ_RECOVERY  in  1  restore saved MEM_WB
- mem_req  out  1  access request
- mem_we  out  1  1 = write
- mem_addr  out  32  EX_MEM[63:32]
- mem_wdata  out  32  EX_MEM[31:0]
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  access complete
- stall  out  1  freeze PC/IF_ID/ID_EX/EX_MEM this cycle
- bus_err  out  1  one-cycle pulse on timeout
- EX_MEM_Rd  out  5  EX_MEM[68:64]
- EX_MEM_RegWrite  out  1  EX_MEM[71]
- EX_MEM_RdData  out  32  non-load writeback value of current EX_MEM (see WbSel)
- MEM_WB  out  38  [31:0] RegWriteData, [36:32] WriteReg, [37] RegWrite
- MEM_WB_Rd, MEM_WB_RegWrite, MEM_WB_RdData  out  5/1/32  slices of MEM_WB

Behaviour:
- Reset: MEM_WB=0, backup register=0, FSM=IDLE, wait counter=0, bus_err=0. mem_req/stall are combinational and therefore 0 while EX_MEM=0.
- Access detection: acc = MemRead | MemWrite. If both are set, it is a write. mem_req = acc while FSM is IDLE or WAIT. mem_we = MemWrite.
- WbSel (combinational):
  - LUOp=1 -> LUData.
  - else MemToReg 00 -> ALU result; 01 -> mem_rdata; 10 -> PC_Plus4; 11 -> 0.
  - EX_MEM_RdData uses the same selection with 01 mapped to the ALU result.
- FSM states IDLE, WAIT:
  - IDLE, acc & mem_ack: zero-wait access; stall=0; MEM_WB captures normally.
  - IDLE, acc & ~mem_ack: go to WAIT, counter<=1, stall=1.
  - WAIT, ~mem_ack: counter++, stall=1, MEM_WB<=bubble (all 0).
  - WAIT, mem_ack: go to IDLE, stall=0, MEM_WB captures {RegWrite, WriteReg, WbSel}.
  - WAIT, counter==TIMEOUT & ~mem_ack: go to IDLE, stall=0, bus_err=1 for one cycle, MEM_WB<=bubble. The load result is discarded and the store is considered lost.
- The IDLE->WAIT cycle also writes a bubble to MEM_WB.
- While stall=1, EX_MEM is held upstream, so address, data and we stay stable. The bench checks this.
- mem_ack while mem_req=0 is ignored.
- Normal capture (no access, or the access completes): MEM_WB <= {EX_MEM[71], EX_MEM[68:64], WbSel}. Latency is 1 cycle from EX_MEM to MEM_WB when zero-wait.
- Priority per clock edge: reset > IRQ_RECOVERY (MEM_WB<=backup) > IRQ_BACKUP (backup<=MEM_WB, MEM_WB<=0) > normal.
- IRQ_BACKUP/RECOVERY do not affect the FSM. An in-flight access completes or times out, but its capture is overridden in that cycle.
- Reset mid-WAIT: FSM returns to IDLE immediately and the counter clears. The memory side must tolerate a dropped request.
- Stores never write MEM_WB data other than WbSel. Their RegWrite comes from EX_MEM, normally 0.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: if acc and mem_addr[1:0]!=0, then mem_req=0, stall=0, bus_err pulses the next cycle (registered), and MEM_WB<=bubble.
- Undefined: mem_addr is passed through unchanged and the memory ignores the low bits.

Decomposition:
- Shared package/header pipe_defs:
  - EX_MEM and MEM_WB field bit-position localparams (EXM_ALU_LO/HI etc.).
  - MEM_WB width 38.
  - MemToReg codes MTR_ALU=2'b00, MTR_MEM=2'b01, MTR_PC4=2'b10.
  - FSM encodings S_IDLE, S_WAIT.
- One sub-module, mem_handshake: FSM, wait counter and timeout. Outputs are stall, capture_en, bubble and bus_err.
- Writeback mux and registers stay in mem_stage.

Test Plan:
- ALU op, zero-wait: EX_MEM ALU=0x0000_1234, WriteReg=8, RegWrite=1, MemToReg=00 -> next cycle MEM_WB={1,8,0x1234}, stall never 1.
- Load with 3 wait states: MemRead=1, addr=0x40, ack on the 4th cycle, rdata=0xDEADBEEF -> stall=1 for 3 cycles, MEM_WB bubbles for 3 cycles, then MEM_WB data=0xDEADBEEF.
- Timeout with TIMEOUT=4 and ack never asserted -> stall high 4 cycles, bus_err 1-cycle pulse, MEM_WB=0, FSM idle, next instruction proceeds.
- LUOp=1, LUData=0xABCD0000, MemToReg=10 -> MEM_WB data=0xABCD0000. Then LUOp=0, PC_Plus4=0x0040_0010 -> MEM_WB data=0x0040_0010 and EX_MEM_RdData matches the cycle before.
- IRQ_BACKUP with MEM_WB={1,5,0x77} -> MEM_WB=0. Three cycles later IRQ_RECOVERY -> MEM_WB={1,5,0x77}. Both asserted together -> recovery wins.
- MEM_ALIGN_CHECK_EN: store to 0x42 -> mem_req stays 0, bus_err pulses, MEM_WB=0. Without the macro -> mem_req=1, mem_addr=0x42.

Source files
------------

// File: rtl/pipe_defs.sv
// Shared EX_MEM / MEM_WB field layout, writeback codes and MEM FSM states.
package pipe_defs;

    localparam int EXM_W      = 139;
    localparam int EXM_WD_LO  = 0;
    localparam int EXM_WD_HI  = 31;
    localparam int EXM_ALU_LO = 32;
    localparam int EXM_ALU_HI = 63;
    localparam int EXM_RD_LO  = 64;
    localparam int EXM_RD_HI  = 68;
    localparam int EXM_MRD    = 69;
    localparam int EXM_MWR    = 70;
    localparam int EXM_RW     = 71;
    localparam int EXM_MTR_LO = 72;
    localparam int EXM_MTR_HI = 73;
    localparam int EXM_PC4_LO = 74;
    localparam int EXM_PC4_HI = 105;
    localparam int EXM_LUD_LO = 106;
    localparam int EXM_LUD_HI = 137;
    localparam int EXM_LUOP   = 138;

    localparam int MWB_W      = 38;
    localparam int MWB_DAT_HI = 31;
    localparam int MWB_RD_LO  = 32;
    localparam int MWB_RD_HI  = 36;
    localparam int MWB_RW     = 37;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

    function automatic logic [31:0] wb_sel(
        input logic        luop,
        input logic [1:0]  mtr,
        input logic [31:0] alu,
        input logic [31:0] mem,
        input logic [31:0] pc4,
        input logic [31:0] lud
    );
        logic [31:0] r;
        r = '0;
        if (luop) begin
            r = lud;
        end else begin
            unique case (mtr)
                MTR_ALU: r = alu;
                MTR_MEM: r = mem;
                MTR_PC4: r = pc4;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_handshake.sv
// MEM access handshake: wait-state FSM, wait counter and timeout abort.
module mem_handshake
    import pipe_defs::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset_b,
    input  logic acc,
    input  logic misalign,
    input  logic mem_ack,
    output logic stall,
    output logic capture_en,
    output logic bubble,
    output logic bus_err
);

    mem_state_e state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic err_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall    = 1'b0;
        bubble   = 1'b0;
        err_nx   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (misalign) begin
                    bubble = 1'b1;
                    err_nx = 1'b1;
                end else if (acc && !mem_ack) begin
                    state_nx = S_WAIT;
                    cnt_nx   = CNT_W'(1);
                    stall    = 1'b1;
                    bubble   = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    // abort: pipe moves on, result lost
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                    bubble   = 1'b1;
                    err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        capture_en = !bubble;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bus_err <= err_nx;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data access, writeback select, MEM_WB register, IRQ save/restore.
// Optional MEM_ALIGN_CHECK_EN rejects word accesses with nonzero address bits [1:0].
module mem_stage
    import pipe_defs::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic [138:0] EX_MEM,
    input  logic         IRQ_BACKUP,
    input  logic         IRQ_RECOVERY,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ack,
    output logic         stall,
    output logic         bus_err,
    output logic [4:0]   EX_MEM_Rd,
    output logic         EX_MEM_RegWrite,
    output logic [31:0]  EX_MEM_RdData,
    output logic [37:0]  MEM_WB,
    output logic [4:0]   MEM_WB_Rd,
    output logic         MEM_WB_RegWrite,
    output logic [31:0]  MEM_WB_RdData
);

    logic [31:0] alu, pc4, lud, wb_data;
    logic [1:0]  mtr;
    logic        luop, mrd, mwr, acc, misalign;
    logic        capture_en, bubble;
    logic [MWB_W-1:0] mwb_nx, backup;

    assign alu  = EX_MEM[EXM_ALU_HI:EXM_ALU_LO];
    assign pc4  = EX_MEM[EXM_PC4_HI:EXM_PC4_LO];
    assign lud  = EX_MEM[EXM_LUD_HI:EXM_LUD_LO];
    assign mtr  = EX_MEM[EXM_MTR_HI:EXM_MTR_LO];
    assign luop = EX_MEM[EXM_LUOP];
    assign mrd  = EX_MEM[EXM_MRD];
    assign mwr  = EX_MEM[EXM_MWR];
    assign acc  = mrd | mwr;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = acc && (alu[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign mem_req   = acc & ~misalign;
    assign mem_we    = mwr;
    assign mem_addr  = alu;
    assign mem_wdata = EX_MEM[EXM_WD_HI:EXM_WD_LO];

    assign EX_MEM_Rd       = EX_MEM[EXM_RD_HI:EXM_RD_LO];
    assign EX_MEM_RegWrite = EX_MEM[EXM_RW];
    // forwarding tap cannot see load data yet, so it reports the address
    assign EX_MEM_RdData   = wb_sel(luop, mtr, alu, alu, pc4, lud);

    assign wb_data = wb_sel(luop, mtr, alu, mem_rdata, pc4, lud);
    assign mwb_nx  = {EX_MEM_RegWrite, EX_MEM_Rd, wb_data};

    mem_handshake #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_hs (
        .clk        (clk),
        .reset_b    (reset_b),
        .acc        (acc),
        .misalign   (misalign),
        .mem_ack    (mem_ack),
        .stall      (stall),
        .capture_en (capture_en),
        .bubble     (bubble),
        .bus_err    (bus_err)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            MEM_WB <= '0;
            backup <= '0;
        end else if (IRQ_RECOVERY) begin
            MEM_WB <= backup;
        end else if (IRQ_BACKUP) begin
            backup <= MEM_WB;
            MEM_WB <= '0;
        end else if (capture_en) begin
            MEM_WB <= mwb_nx;
        end else if (bubble) begin
            MEM_WB <= '0;
        end
    end

    assign MEM_WB_Rd       = MEM_WB[MWB_RD_HI:MWB_RD_LO];
    assign MEM_WB_RegWrite = MEM_WB[MWB_RW];
    assign MEM_WB_RdData   = MEM_WB[MWB_DAT_HI:0];

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, corner sequences, random vs model.
module tb_mem_stage;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] wd;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        mrd;
        logic        mwr;
        logic        rw;
        logic [1:0]  mtr;
        logic [31:0] pc4;
        logic [31:0] lud;
        logic        luop;
    } instr_t;

    typedef struct {
        instr_t      in;
        logic        ack;
        logic [31:0] rdata;
        logic [37:0] exp_wb;
        logic [31:0] exp_rdd;
        logic        exp_req;
    } vec_t;

    logic         clk;
    logic         reset_b;
    logic [138:0] ex_mem;
    logic         irq_backup, irq_recovery;
    logic         mem_req, mem_we, mem_ack;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic         stall, bus_err;
    logic [4:0]   ex_mem_rd, mem_wb_rd;
    logic         ex_mem_rw, mem_wb_rw;
    logic [31:0]  ex_mem_rdd, mem_wb_rdd;
    logic [37:0]  mem_wb;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk             (clk),
        .reset_b         (reset_b),
        .EX_MEM          (ex_mem),
        .IRQ_BACKUP      (irq_backup),
        .IRQ_RECOVERY    (irq_recovery),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack),
        .stall           (stall),
        .bus_err         (bus_err),
        .EX_MEM_Rd       (ex_mem_rd),
        .EX_MEM_RegWrite (ex_mem_rw),
        .EX_MEM_RdData   (ex_mem_rdd),
        .MEM_WB          (mem_wb),
        .MEM_WB_Rd       (mem_wb_rd),
        .MEM_WB_RegWrite (mem_wb_rw),
        .MEM_WB_RdData   (mem_wb_rdd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk(
        input logic [31:0] alu, input logic [4:0] rd, input logic rw,
        input logic mrd, input logic mwr, input logic [1:0] mtr,
        input logic [31:0] pc4, input logic [31:0] lud, input logic luop,
        input logic [31:0] wd
    );
        instr_t t;
        t.alu = alu; t.rd = rd; t.rw = rw; t.mrd = mrd; t.mwr = mwr;
        t.mtr = mtr; t.pc4 = pc4; t.lud = lud; t.luop = luop; t.wd = wd;
        return t;
    endfunction

    function automatic logic [138:0] pack(input instr_t t);
        return {t.luop, t.lud, t.pc4, t.mtr, t.rw, t.mwr, t.mrd, t.rd, t.alu, t.wd};
    endfunction

    // writeback value straight from the field rules
    function automatic logic [31:0] ref_wb(input instr_t t, input logic [31:0] memv);
        if (t.luop) return t.lud;
        case (t.mtr)
            2'b00:   return t.alu;
            2'b01:   return memv;
            2'b10:   return t.pc4;
            default: return 32'h0;
        endcase
    endfunction

    // one instruction whose ack arrives after lat wait cycles (lat > TO never acks)
    task automatic run_instr(input instr_t in, input int lat);
        logic        acc;
        int          nst;
        logic [31:0] rdv;
        logic [37:0] exp;
        acc = in.mrd | in.mwr;
        nst = acc ? ((lat < TO) ? lat : TO) : 0;
        ex_mem = pack(in);
        for (int i = 0; i <= nst; i++) begin
            rdv = $urandom;
            mem_rdata = rdv;
            mem_ack = acc ? (i == lat) : 1'($urandom_range(0, 1));
            #1;
            chk("stall", 64'(stall), 64'(i < nst));
            chk("mem_req", 64'(mem_req), 64'(acc));
            if (acc) begin
                chk("mem_addr", 64'(mem_addr), 64'(in.alu));
                chk("mem_wdata", 64'(mem_wdata), 64'(in.wd));
                chk("mem_we", 64'(mem_we), 64'(in.mwr));
            end
            chk("ex_rdd", 64'(ex_mem_rdd), 64'(ref_wb(in, in.alu)));
            @(posedge clk);
            #1;
            if (i < nst || (acc && lat > TO)) exp = '0;
            else exp = {in.rw, in.rd, ref_wb(in, rdv)};
            chk("mem_wb", 64'(mem_wb), 64'(exp));
            chk("bus_err", 64'(bus_err), 64'(acc && lat > TO && i == nst));
        end
        mem_ack = 1'b0;
    endtask

    vec_t tbl[8];
    instr_t t;

    initial begin
        reset_b = 1'b0; ex_mem = '0; irq_backup = 1'b0; irq_recovery = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;

        tbl[0] = '{mk(32'h1234, 5'd8, 1, 0, 0, 2'b00, 32'h10, 32'h5, 0, 0),
                   0, 32'hFFFF, {1'b1, 5'd8, 32'h1234}, 32'h1234, 0};
        tbl[1] = '{mk(32'h5555, 5'd2, 1, 0, 0, 2'b10, 32'h100, 32'hABCD0000, 1, 0),
                   0, 32'h0, {1'b1, 5'd2, 32'hABCD0000}, 32'hABCD0000, 0};
        tbl[2] = '{mk(32'h5555, 5'd2, 1, 0, 0, 2'b10, 32'h00400010, 32'hABCD0000, 0, 0),
                   0, 32'h0, {1'b1, 5'd2, 32'h00400010}, 32'h00400010, 0};
        tbl[3] = '{mk(32'h99, 5'd4, 1, 0, 0, 2'b11, 32'h44, 32'h55, 0, 0),
                   0, 32'h66, {1'b1, 5'd4, 32'h0}, 32'h0, 0};
        tbl[4] = '{mk(32'h100, 5'd7, 1, 1, 0, 2'b01, 32'h44, 32'h55, 0, 32'h9),
                   1, 32'hCAFEF00D, {1'b1, 5'd7, 32'hCAFEF00D}, 32'h100, 1};
        tbl[5] = '{mk(32'h200, 5'd3, 0, 0, 1, 2'b00, 32'h44, 32'h55, 0, 32'h1111),
                   1, 32'h0, {1'b0, 5'd3, 32'h200}, 32'h200, 1};
        tbl[6] = '{mk(32'h300, 5'd1, 1, 1, 1, 2'b01, 32'h44, 32'h55, 0, 32'h2222),
                   1, 32'h4242, {1'b1, 5'd1, 32'h4242}, 32'h300, 1};
        tbl[7] = '{mk(32'h88, 5'd6, 1, 0, 0, 2'b01, 32'h44, 32'h55, 0, 0),
                   1, 32'h7777, {1'b1, 5'd6, 32'h7777}, 32'h88, 0};

        step();
        step();
        chk("rst_mem_wb", 64'(mem_wb), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_req", 64'(mem_req), 64'h0);
        chk("rst_bus_err", 64'(bus_err), 64'h0);
        reset_b = 1'b1;

        foreach (tbl[k]) begin
            ex_mem = pack(tbl[k].in);
            mem_ack = tbl[k].ack;
            mem_rdata = tbl[k].rdata;
            #1;
            chk("tbl_stall", 64'(stall), 64'h0);
            chk("tbl_req", 64'(mem_req), 64'(tbl[k].exp_req));
            chk("tbl_we", 64'(mem_we), 64'(tbl[k].in.mwr));
            chk("tbl_ex_rd", 64'(ex_mem_rd), 64'(tbl[k].in.rd));
            chk("tbl_ex_rw", 64'(ex_mem_rw), 64'(tbl[k].in.rw));
            chk("tbl_ex_rdd", 64'(ex_mem_rdd), 64'(tbl[k].exp_rdd));
            step();
            chk("tbl_mem_wb", 64'(mem_wb), 64'(tbl[k].exp_wb));
            chk("tbl_wb_rd", 64'(mem_wb_rd), 64'(tbl[k].exp_wb[36:32]));
            chk("tbl_wb_rw", 64'(mem_wb_rw), 64'(tbl[k].exp_wb[37]));
            chk("tbl_wb_rdd", 64'(mem_wb_rdd), 64'(tbl[k].exp_wb[31:0]));
        end
        mem_ack = 1'b0;

        // load with three wait states, then a timeout, then a normal op
        run_instr(mk(32'h40, 5'd3, 1, 1, 0, 2'b01, 32'h4, 32'h5, 0, 0), 3);
        run_instr(mk(32'h80, 5'd9, 1, 1, 0, 2'b01, 32'h4, 32'h5, 0, 0), 99);
        run_instr(mk(32'h31, 5'd10, 1, 0, 0, 2'b00, 32'h4, 32'h5, 0, 0), 0);

        // IRQ backup / recovery, recovery wins when both set
        ex_mem = pack(mk(32'h77, 5'd5, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        step();
        chk("irq_pre", 64'(mem_wb), 64'({1'b1, 5'd5, 32'h77}));
        ex_mem = pack(mk(32'h99, 5'd9, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        irq_backup = 1'b1;
        step();
        chk("irq_backup", 64'(mem_wb), 64'h0);
        irq_backup = 1'b0;
        ex_mem = '0;
        step(); step(); step();
        irq_recovery = 1'b1;
        step();
        chk("irq_recover", 64'(mem_wb), 64'({1'b1, 5'd5, 32'h77}));
        irq_recovery = 1'b0;
        ex_mem = pack(mk(32'h99, 5'd9, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        step();
        chk("irq_mid", 64'(mem_wb), 64'({1'b1, 5'd9, 32'h99}));
        irq_backup = 1'b1; irq_recovery = 1'b1;
        step();
        chk("irq_both", 64'(mem_wb), 64'({1'b1, 5'd5, 32'h77}));
        irq_backup = 1'b0; irq_recovery = 1'b0;

        // reset in the middle of a wait, then a full timeout must still take TO stalls
        ex_mem = pack(mk(32'h80, 5'd2, 1, 1, 0, 2'b01, 0, 0, 0, 0));
        mem_ack = 1'b0;
        step(); step(); step();
        reset_b = 1'b0;
        #1;
        chk("rst_wait_wb", 64'(mem_wb), 64'h0);
        step();
        reset_b = 1'b1;
        run_instr(mk(32'h80, 5'd2, 1, 1, 0, 2'b01, 0, 0, 0, 0), 99);

        // misaligned store
        t = mk(32'h42, 5'd4, 0, 0, 1, 2'b00, 0, 0, 0, 32'h5A5A);
        ex_mem = pack(t);
        mem_ack = 1'b1;
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_req", 64'(mem_req), 64'h0);
        chk("mis_stall", 64'(stall), 64'h0);
        step();
        chk("mis_wb", 64'(mem_wb), 64'h0);
        chk("mis_err", 64'(bus_err), 64'h1);
        ex_mem = '0;
        mem_ack = 1'b0;
        step();
        chk("mis_err_clr", 64'(bus_err), 64'h0);
`else
        chk("mis_req", 64'(mem_req), 64'h1);
        chk("mis_addr", 64'(mem_addr), 64'h42);
        step();
        chk("mis_wb", 64'(mem_wb), 64'({1'b0, 5'd4, 32'h42}));
        chk("mis_err", 64'(bus_err), 64'h0);
        mem_ack = 1'b0;
`endif

        // random instructions against the latency model
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            t.wd   = $urandom;
            t.alu  = $urandom;
            t.rd   = 5'($urandom);
            t.rw   = 1'($urandom);
            t.mtr  = 2'($urandom);
            t.pc4  = $urandom;
            t.lud  = $urandom;
            t.luop = ($urandom_range(0, 7) == 0);
            t.mrd  = (kind == 1 || kind == 3);
            t.mwr  = (kind == 2 || kind == 3);
            if (t.mrd | t.mwr) t.alu[1:0] = 2'b00;
            run_instr(t, $urandom_range(0, TO + 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
